// File: rtl/sword_pkg.sv
// Shared types and helpers for the sword-attack sequencer and sprite address logic.
// Frame-count helpers keep zero-length phases at one frame.
package sword_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WINDUP,
        STRIKE,
        RECOVER,
        COOLDOWN
    } atk_state_t;

    typedef enum logic [1:0] {
        UP,
        DOWN,
        LEFT,
        RIGHT
    } dir_t;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    // Counter reload value: a phase of f frames counts f-1 down to 0.
    function automatic int frame_load(input int f);
        return (f > 0) ? f - 1 : 0;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sprite_box_addr.sv
// Sprite bounding-box test with registered ROM address and on-mask.
// Offsets are 11-bit signed so positions left/above the sprite never alias.
module sprite_box_addr
    import sword_pkg::*;
#(
    parameter int SPR_W = 32,
    parameter int SPR_H = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       visible,
    input  logic [9:0] sprite_x,
    input  logic [9:0] sprite_y,
    input  logic [9:0] draw_x,
    input  logic [9:0] draw_y,
    output logic [9:0] addr,
    output logic       on
);

    logic [10:0] dx;
    logic [10:0] dy;
    logic [20:0] lin;
    logic        in_box;
    logic        on_screen;

    // Pixel offsets relative to the sprite origin and the box test.
    always_comb begin
        dx = {1'b0, draw_x} - {1'b0, sprite_x};
        dy = {1'b0, draw_y} - {1'b0, sprite_y};
        on_screen = ({22'b0, draw_x} < SCREEN_W) &&
                    ({22'b0, draw_y} < SCREEN_H);
        in_box = !dx[10] && !dy[10] &&
                 (dx < 11'(SPR_W)) && (dy < 11'(SPR_H)) &&
                 on_screen;
        lin = 21'(dy) * 21'(SPR_W) + 21'(dx);
    end

    // Address and mask share one register stage to line up with ROM q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr <= '0;
            on   <= 1'b0;
        end else begin
            addr <= in_box ? lin[9:0] : '0;
            on   <= visible & in_box;
        end
    end

endmodule

// File: rtl/sword_attack_sequencer.sv
// Sword attack FSM: wind-up, strike, recover, cooldown stepped on frame ticks.
// Drives frame select and, via sprite_box_addr, the per-pixel ROM address.
module sword_attack_sequencer
    import sword_pkg::*;
#(
    parameter int SPR_W      = 32,
    parameter int SPR_H      = 32,
    parameter int WINDUP_F   = 4,
    parameter int STRIKE_F   = 8,
    parameter int RECOVER_F  = 4,
    parameter int COOLDOWN_F = 6
) (
    input  logic       vga_clk,
    input  logic       reset_n,
    input  logic       frame_tick,
    input  logic       attack_btn,
    input  logic [1:0] facing,
    input  logic [9:0] link_x,
    input  logic [9:0] link_y,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    output logic [9:0] rom_address,
    output logic [2:0] frame_sel,
    output logic       sprite_on,
    output logic       busy,
    output logic       attack_done
);

    localparam int MAXF = max2(max2(WINDUP_F, STRIKE_F),
                               max2(RECOVER_F, COOLDOWN_F));
    localparam int CW   = (MAXF > 0) ? $clog2(MAXF + 1) : 1;

    localparam logic [CW-1:0] LD_W = CW'(frame_load(WINDUP_F));
    localparam logic [CW-1:0] LD_S = CW'(frame_load(STRIKE_F));
    localparam logic [CW-1:0] LD_R = CW'(frame_load(RECOVER_F));
    localparam logic [CW-1:0] LD_C = CW'(frame_load(COOLDOWN_F));

    atk_state_t    state;
    dir_t          dir;
    logic [CW-1:0] cnt;
    logic          btn_q;
    logic          pending;
    logic          vis;
    logic          rise;

    assign rise = attack_btn & ~btn_q;

    // Phase sequencing; every state/dir/phase change happens on frame_tick.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            dir         <= UP;
            cnt         <= '0;
            btn_q       <= 1'b0;
            pending     <= 1'b0;
            vis         <= 1'b0;
            busy        <= 1'b0;
            frame_sel   <= 3'b000;
            attack_done <= 1'b0;
        end else begin
            btn_q       <= attack_btn;
            attack_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (frame_tick && (pending || rise)) begin
                        state     <= WINDUP;
                        dir       <= dir_t'(facing);
                        cnt       <= LD_W;
                        pending   <= 1'b0;
                        vis       <= 1'b1;
                        busy      <= 1'b1;
                        frame_sel <= {facing, 1'b0};
                    end else if (rise) begin
                        pending <= 1'b1;
                    end
                end
                WINDUP: begin
                    if (frame_tick) begin
                        if (cnt == '0) begin
                            state     <= STRIKE;
                            cnt       <= LD_S;
                            frame_sel <= {dir, 1'b1};
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                end
                STRIKE: begin
                    if (frame_tick) begin
                        if (cnt == '0) begin
                            state     <= RECOVER;
                            cnt       <= LD_R;
                            frame_sel <= {dir, 1'b0};
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                end
                RECOVER: begin
                    if (frame_tick) begin
                        if (cnt == '0) begin
                            state       <= COOLDOWN;
                            cnt         <= LD_C;
                            vis         <= 1'b0;
                            attack_done <= 1'b1;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                end
                COOLDOWN: begin
                    if (frame_tick) begin
                        if (cnt == '0) begin
                            state     <= IDLE;
                            cnt       <= '0;
                            busy      <= 1'b0;
                            frame_sel <= 3'b000;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    vis       <= 1'b0;
                    busy      <= 1'b0;
                    frame_sel <= 3'b000;
                end
            endcase
        end
    end

    sprite_box_addr #(
        .SPR_W (SPR_W),
        .SPR_H (SPR_H)
    ) u_box (
        .clk      (vga_clk),
        .rst_n    (reset_n),
        .visible  (vis),
        .sprite_x (link_x),
        .sprite_y (link_y),
        .draw_x   (DrawX),
        .draw_y   (DrawY),
        .addr     (rom_address),
        .on       (sprite_on)
    );

endmodule

// File: tb/tb_sword_attack_sequencer.sv
// Self-checking bench: attack timeline model by frame age, plus directed cases.
module tb_sword_attack_sequencer;

    localparam int W   = 4;
    localparam int S   = 8;
    localparam int R   = 4;
    localparam int C   = 6;
    localparam int TOT = W + S + R + C;

    logic       vga_clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic       attack_btn = 1'b0;
    logic [1:0] facing = 2'd0;
    logic [9:0] link_x = 10'd0;
    logic [9:0] link_y = 10'd0;
    logic [9:0] DrawX = 10'd0;
    logic [9:0] DrawY = 10'd0;
    logic [9:0] rom_address;
    logic [2:0] frame_sel;
    logic       sprite_on;
    logic       busy;
    logic       attack_done;

    sword_attack_sequencer dut (
        .vga_clk     (vga_clk),
        .reset_n     (reset_n),
        .frame_tick  (frame_tick),
        .attack_btn  (attack_btn),
        .facing      (facing),
        .link_x      (link_x),
        .link_y      (link_y),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .rom_address (rom_address),
        .frame_sel   (frame_sel),
        .sprite_on   (sprite_on),
        .busy        (busy),
        .attack_done (attack_done)
    );

    always #5 vga_clk = ~vga_clk;

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;

    // Model: age = frame ticks since attack start, -1 when idle.
    int age = -1;
    bit pend = 0;
    bit prev_btn = 0;
    int mdir = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit visible(input int a);
        return (a >= 0) && (a < W + S + R);
    endfunction

    task automatic model_reset();
        age = -1;
        pend = 0;
        prev_btn = 0;
        mdir = 0;
    endtask

    // Predict, advance one clock, then compare all outputs.
    task automatic cyc();
        bit rise;
        bit inb;
        bit e_done;
        int dx;
        int dy;
        int e_addr;
        int e_on;
        int e_fs;
        rise = attack_btn && !prev_btn;
        dx = int'(DrawX) - int'(link_x);
        dy = int'(DrawY) - int'(link_y);
        inb = dx >= 0 && dx < 32 && dy >= 0 && dy < 32 &&
              DrawX < 640 && DrawY < 480;
        e_addr = inb ? dy * 32 + dx : 0;
        e_on = (visible(age) && inb) ? 1 : 0;
        e_done = 0;
        if (age < 0) begin
            if (frame_tick && (pend || rise)) begin
                age = 0;
                mdir = int'(facing);
                pend = 0;
            end else if (rise) begin
                pend = 1;
            end
        end else if (frame_tick) begin
            age++;
            if (age == W + S + R) e_done = 1;
            if (age == TOT) age = -1;
        end
        prev_btn = attack_btn;
        if (age < 0) e_fs = 0;
        else e_fs = mdir * 2 + ((age >= W && age < W + S) ? 1 : 0);
        @(posedge vga_clk);
        #1;
        if (attack_done === 1'b1) done_cnt++;
        chk("busy", 32'(busy), (age >= 0) ? 1 : 0);
        chk("frame_sel", 32'(frame_sel), e_fs);
        chk("attack_done", 32'(attack_done), 32'(e_done));
        chk("sprite_on", 32'(sprite_on), e_on);
        chk("rom_address", 32'(rom_address), e_addr);
    endtask

    task automatic tick(input int gap);
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        repeat (gap) cyc();
    endtask

    task automatic press();
        attack_btn = 1'b1;
        cyc();
        attack_btn = 1'b0;
        cyc();
    endtask

    initial begin
        // Reset state.
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(posedge vga_clk);
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_frame_sel", 32'(frame_sel), 0);
        chk("rst_sprite_on", 32'(sprite_on), 0);
        chk("rst_rom_address", 32'(rom_address), 0);
        chk("rst_attack_done", 32'(attack_done), 0);
        reset_n = 1'b1;
        repeat (3) cyc();

        // Full attack: facing left, facing changes at tick 5.
        facing = 2'd2;
        link_x = 10'd100;
        link_y = 10'd50;
        DrawX = 10'd110;
        DrawY = 10'd60;
        done_cnt = 0;
        press();
        tick(1);
        chk("t6_dir_start", 32'(frame_sel), 32'b100);
        for (int t = 1; t < 6; t++) begin
            if (t == 5) facing = 2'd0;
            tick(1);
        end
        chk("t2_strike_sel", 32'(frame_sel), 32'b101);
        // Box corner and edges while in STRIKE.
        DrawX = 10'd131;
        DrawY = 10'd81;
        cyc();
        chk("t4_addr_corner", 32'(rom_address), 1023);
        chk("t4_on_corner", 32'(sprite_on), 1);
        DrawX = 10'd132;
        cyc();
        chk("t4_off_right", 32'(sprite_on), 0);
        link_x = 10'd620;
        DrawX = 10'd639;
        DrawY = 10'd50;
        cyc();
        chk("t5_addr_clip", 32'(rom_address), 19);
        chk("t5_on_clip", 32'(sprite_on), 1);
        DrawX = 10'd0;
        cyc();
        chk("t5_no_wrap", 32'(sprite_on), 0);
        for (int t = 6; t < TOT + 3; t++) tick(1);
        chk("t2_done_once", 32'(done_cnt), 1);
        chk("t2_idle_end", 32'(busy), 0);

        // Reset in the middle of STRIKE.
        link_x = 10'd100;
        DrawX = 10'd105;
        DrawY = 10'd55;
        press();
        for (int t = 0; t < 7; t++) tick(1);
        chk("t1_pre_on", 32'(sprite_on), 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t1_busy_async", 32'(busy), 0);
        chk("t1_sel_async", 32'(frame_sel), 0);
        chk("t1_on_async", 32'(sprite_on), 0);
        model_reset();
        repeat (3) @(posedge vga_clk);
        #1;
        reset_n = 1'b1;
        repeat (2) tick(1);
        chk("t1_idle_after", 32'(busy), 0);

        // Button held for 40 frames, then an edge in COOLDOWN.
        done_cnt = 0;
        attack_btn = 1'b1;
        for (int t = 0; t < 40; t++) tick(2);
        chk("t3_one_attack", 32'(done_cnt), 1);
        chk("t3_idle_held", 32'(busy), 0);
        attack_btn = 1'b0;
        cyc();
        done_cnt = 0;
        press();
        for (int t = 0; t < W + S + R + 2; t++) tick(1);
        press();
        for (int t = 0; t < 8; t++) tick(1);
        chk("t3_cool_ignored", 32'(done_cnt), 1);
        chk("t3_busy_end", 32'(busy), 0);

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            frame_tick = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 9) == 0) attack_btn = ~attack_btn;
            facing = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 49) == 0) begin
                link_x = 10'($urandom_range(0, 639));
                link_y = 10'($urandom_range(0, 479));
            end
            DrawX = 10'((int'(link_x) + $urandom_range(0, 40) + 636) % 640);
            DrawY = 10'((int'(link_y) + $urandom_range(0, 40) + 476) % 480);
            cyc();
        end
        frame_tick = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
